// File: rtl/rtc_calendar_core_pkg.sv
// Shared widths, BCD calendar constants and helpers
// for the RTC/calendar core.
package rtc_pkg;

  localparam int BCD2_W = 8;
  localparam int YEAR_W = 16;
  localparam int TIME_W = 24;
  localparam int DATE_W = 32;

  localparam logic [7:0] BCD_00   = 8'h00;
  localparam logic [7:0] BCD_01   = 8'h01;
  localparam logic [7:0] BCD_99   = 8'h99;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MON_MAX  = 8'h12;
  localparam logic [7:0] DIM_31   = 8'h31;
  localparam logic [7:0] DIM_30   = 8'h30;
  localparam logic [7:0] DIM_29   = 8'h29;
  localparam logic [7:0] DIM_28   = 8'h28;
  localparam logic [7:0] RST_DAY  = 8'h01;
  localparam logic [7:0] RST_MON  = 8'h01;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_time_t;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
  } rtc_date_t;

  // tens parity selects which units digits make the pair a multiple of 4
  function automatic logic bcd_div4(input logic [7:0] b);
    logic [3:0] u;
    u = b[3:0];
    if (b[4])
      return (u == 4'd2) || (u == 4'd6);
    return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
  endfunction

  function automatic logic bcd_leap(input logic [15:0] y);
    if (y[7:0] == 8'h00)
      return bcd_div4(y[15:8]);
    return bcd_div4(y[7:0]);
  endfunction

  function automatic logic [7:0] bcd_days_in_month(
    input logic [7:0] m,
    input logic       leap
  );
    logic [7:0] d;
    unique case (1'b1)
      (m == 8'h02): d = leap ? DIM_29 : DIM_28;
      (m == 8'h04) || (m == 8'h06) ||
      (m == 8'h09) || (m == 8'h11): d = DIM_30;
      default: d = DIM_31;
    endcase
    return d;
  endfunction

  function automatic logic bcd_valid(input logic [55:0] n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 14; i++)
      if (n[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rtc_calendar_core_if.sv
// Load handshake bundle between a host and the
// RTC/calendar core.
interface rtc_calendar_core_if;
  import rtc_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [TIME_W-1:0] load_time;
  logic [DATE_W-1:0] load_date;
  logic              load_err;

  modport master (
    output load_valid, load_time, load_date,
    input  load_ready, load_err
  );

  modport slave (
    input  load_valid, load_time, load_date,
    output load_ready, load_err
  );

endinterface

// File: rtl/rtc_calendar_core_bcd2_counter.sv
// Two-digit BCD counter with load, increment and
// wrap carry; the i_max port can only tighten MAX.
module rtc_bcd2_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MIN     = 8'h00,
  parameter logic [7:0] MAX     = 8'h99,
  parameter logic [7:0] RST_VAL = MIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [BCD2_W-1:0] i_ld_val,
  input  logic              i_inc,
  input  logic [BCD2_W-1:0] i_max,
  output logic [BCD2_W-1:0] o_val,
  output logic              o_carry
);

  logic [BCD2_W-1:0] r_val;
  logic [BCD2_W-1:0] w_max;
  logic [BCD2_W-1:0] w_next;

  assign w_max = (i_max < MAX) ? i_max : MAX;

  assign w_next = (r_val[3:0] == 4'd9)
    ? {r_val[7:4] + 4'd1, 4'd0}
    : {r_val[7:4], r_val[3:0] + 4'd1};

  assign o_carry = i_inc & (r_val >= w_max);
  assign o_val   = r_val;

  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_val <= RST_VAL;
    else if (i_load)
      r_val <= i_ld_val;
    else if (i_inc)
      r_val <= o_carry ? MIN : w_next;

endmodule

// File: rtl/rtc_calendar_core.sv
// BCD real-time clock/calendar: prescaler, validated
// load handshake, Gregorian carry chain, event pulses.
module rtc_calendar_core
  import rtc_pkg::*;
#(
  parameter int          CLK_HZ         = 50000000,
  parameter logic [15:0] RESET_YEAR_BCD = 16'h2024,
  parameter int          PS_W =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic                fast,
  rtc_calendar_core_if.slave  lif,
  output logic [7:0]          sec_bcd,
  output logic [7:0]          min_bcd,
  output logic [7:0]          hour_bcd,
  output logic [7:0]          day_bcd,
  output logic [7:0]          month_bcd,
  output logic [YEAR_W-1:0]   year_bcd,
  output logic                sec_tick,
  output logic                day_tick,
  output logic                year_wrap
);

  logic [PS_W-1:0] r_ps;
  logic r_ready, r_err;
  logic r_sec_tick, r_day_tick, r_year_wrap;

  rtc_time_t  w_lt;
  rtc_date_t  w_ldd;
  logic [7:0] w_dim_ld, w_dim_cur;
  logic [7:0] w_yl, w_yh;
  logic w_acc, w_ok, w_ld, w_adv, w_inc, w_ps_top;
  logic w_c_sec, w_c_min, w_c_hour;
  logic w_c_day, w_c_mon, w_c_yl, w_c_yh;

  assign w_lt  = lif.load_time;
  assign w_ldd = lif.load_date;

  assign w_dim_ld = bcd_days_in_month(
    w_ldd.month, bcd_leap(w_ldd.year));
  assign w_dim_cur = bcd_days_in_month(
    month_bcd, bcd_leap(year_bcd));

  assign w_ok = bcd_valid({w_lt, w_ldd})
    & (w_lt.sec  <= SEC_MAX)
    & (w_lt.min  <= MIN_MAX)
    & (w_lt.hour <= HOUR_MAX)
    & (w_ldd.month != BCD_00)
    & (w_ldd.month <= MON_MAX)
    & (w_ldd.day != BCD_00)
    & (w_ldd.day <= w_dim_ld);

  assign w_acc    = lif.load_valid & r_ready;
  assign w_ld     = w_acc & w_ok;
  assign w_ps_top = (r_ps == PS_W'(CLK_HZ - 1));
  assign w_adv    = run_en & (fast | w_ps_top);
  // an accepted load swallows a coincident advance
  assign w_inc    = w_adv & ~w_acc;

  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_ps <= '0;
    else if (w_ld)
      r_ps <= '0;
    else if (run_en)
      r_ps <= (fast | w_ps_top) ? '0 : r_ps + PS_W'(1);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_sec_tick  <= 1'b0;
      r_day_tick  <= 1'b0;
      r_year_wrap <= 1'b0;
    end else begin
      r_ready     <= ~w_acc;
      r_err       <= w_acc & ~w_ok;
      r_sec_tick  <= w_inc;
      r_day_tick  <= w_c_hour;
      r_year_wrap <= w_c_yh;
    end

  rtc_bcd2_counter #(
    .MIN(BCD_00), .MAX(SEC_MAX), .RST_VAL(BCD_00)
  ) u_sec (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_lt.sec), .i_inc(w_inc),
    .i_max(SEC_MAX), .o_val(sec_bcd),
    .o_carry(w_c_sec)
  );

  rtc_bcd2_counter #(
    .MIN(BCD_00), .MAX(MIN_MAX), .RST_VAL(BCD_00)
  ) u_min (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_lt.min), .i_inc(w_c_sec),
    .i_max(MIN_MAX), .o_val(min_bcd),
    .o_carry(w_c_min)
  );

  rtc_bcd2_counter #(
    .MIN(BCD_00), .MAX(HOUR_MAX), .RST_VAL(BCD_00)
  ) u_hour (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_lt.hour), .i_inc(w_c_min),
    .i_max(HOUR_MAX), .o_val(hour_bcd),
    .o_carry(w_c_hour)
  );

  rtc_bcd2_counter #(
    .MIN(BCD_01), .MAX(DIM_31), .RST_VAL(RST_DAY)
  ) u_day (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_ldd.day), .i_inc(w_c_hour),
    .i_max(w_dim_cur), .o_val(day_bcd),
    .o_carry(w_c_day)
  );

  rtc_bcd2_counter #(
    .MIN(BCD_01), .MAX(MON_MAX), .RST_VAL(RST_MON)
  ) u_mon (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_ldd.month), .i_inc(w_c_day),
    .i_max(MON_MAX), .o_val(month_bcd),
    .o_carry(w_c_mon)
  );

  rtc_bcd2_counter #(
    .MIN(BCD_00), .MAX(BCD_99),
    .RST_VAL(RESET_YEAR_BCD[7:0])
  ) u_year_lo (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_ldd.year[7:0]), .i_inc(w_c_mon),
    .i_max(BCD_99), .o_val(w_yl),
    .o_carry(w_c_yl)
  );

  rtc_bcd2_counter #(
    .MIN(BCD_00), .MAX(BCD_99),
    .RST_VAL(RESET_YEAR_BCD[15:8])
  ) u_year_hi (
    .clk(clk), .rst(rst), .i_load(w_ld),
    .i_ld_val(w_ldd.year[15:8]), .i_inc(w_c_yl),
    .i_max(BCD_99), .o_val(w_yh),
    .o_carry(w_c_yh)
  );

  assign year_bcd       = {w_yh, w_yl};
  assign lif.load_ready = r_ready;
  assign lif.load_err   = r_err;
  assign sec_tick       = r_sec_tick;
  assign day_tick       = r_day_tick;
  assign year_wrap      = r_year_wrap;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Self-checking bench for rtc_calendar_core with an
// integer-calendar reference model.
module tb_rtc_calendar_core;
  import rtc_pkg::*;

  localparam int CLK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_en = 1'b0;
  logic fast = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic [7:0] day_bcd, month_bcd;
  logic [15:0] year_bcd;
  logic sec_tick, day_tick, year_wrap;

  rtc_calendar_core_if lif();

  rtc_calendar_core #(
    .CLK_HZ(CLK), .RESET_YEAR_BCD(16'h2024)
  ) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .fast(fast), .lif(lif),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .hour_bcd(hour_bcd), .day_bcd(day_bcd),
    .month_bcd(month_bcd), .year_bcd(year_bcd),
    .sec_tick(sec_tick), .day_tick(day_tick),
    .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_s, m_mi, m_h, m_d, m_mo, m_y, m_ps;
  bit m_rdy, m_err, m_st, m_dt, m_yw;

  typedef struct {
    logic [23:0] t;
    logic [31:0] d;
    logic [23:0] et;
    logic [31:0] ed;
    logic        edt;
    logic        eyw;
  } roll_t;

  typedef struct {
    logic [23:0] t;
    logic [31:0] d;
  } bad_t;

  roll_t rv[7];
  bad_t  bv[8];

  function automatic bit is_leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim(int m, int y);
    if (m == 2) return is_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] b2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] b4(int v);
    return {b2(v / 100), b2(v % 100)};
  endfunction

  function automatic int n2i(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bad_nib(logic [55:0] v);
    bit bad;
    bad = 0;
    for (int i = 0; i < 14; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_mi = 0; m_h = 0;
    m_d = 1; m_mo = 1; m_y = 2024;
    m_ps = 0; m_rdy = 0; m_err = 0;
    m_st = 0; m_dt = 0; m_yw = 0;
  endtask

  task automatic model_advance();
    m_st = 1;
    m_s++;
    if (m_s == 60) begin
      m_s = 0; m_mi++;
      if (m_mi == 60) begin
        m_mi = 0; m_h++;
        if (m_h == 24) begin
          m_h = 0; m_dt = 1; m_d++;
          if (m_d > dim(m_mo, m_y)) begin
            m_d = 1; m_mo++;
            if (m_mo == 13) begin
              m_mo = 1; m_y++;
              if (m_y == 10000) begin
                m_y = 0; m_yw = 1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic model_step();
    bit acc, adv, ok;
    int ls, lmi, lh, ld, lmo, ly;
    acc = lif.load_valid && m_rdy;
    adv = run_en && (fast || m_ps == CLK - 1);
    ls  = n2i(lif.load_time[7:0]);
    lmi = n2i(lif.load_time[15:8]);
    lh  = n2i(lif.load_time[23:16]);
    ld  = n2i(lif.load_date[7:0]);
    lmo = n2i(lif.load_date[15:8]);
    ly  = n2i(lif.load_date[31:24]) * 100 + n2i(lif.load_date[23:16]);
    ok = !bad_nib({lif.load_time, lif.load_date})
      && ls < 60 && lmi < 60 && lh < 24
      && lmo >= 1 && lmo <= 12
      && ld >= 1 && ld <= dim(lmo, ly);
    m_err = acc && !ok;
    m_rdy = !acc;
    m_st = 0; m_dt = 0; m_yw = 0;
    if (acc && ok) begin
      m_s = ls; m_mi = lmi; m_h = lh;
      m_d = ld; m_mo = lmo; m_y = ly;
      m_ps = 0;
    end else begin
      if (run_en)
        m_ps = (fast || m_ps == CLK - 1) ? 0 : m_ps + 1;
      if (adv && !acc) model_advance();
    end
  endtask

  task automatic check_state(string nm);
    logic [60:0] exp, act;
    exp = {b2(m_s), b2(m_mi), b2(m_h), b2(m_d), b2(m_mo),
           b4(m_y), m_rdy, m_err, m_st, m_dt, m_yw};
    act = {sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd,
           year_bcd, lif.load_ready, lif.load_err,
           sec_tick, day_tick, year_wrap};
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_state("cycle");
  endtask

  task automatic gen_load(output logic [23:0] t, output logic [31:0] d);
    int y, mo, dd, h, mi, s;
    if ($urandom % 4 == 0) begin
      t = 24'($urandom);
      d = $urandom;
    end else begin
      y  = ($urandom % 4 == 0) ? 9999 : int'($urandom_range(0, 9999));
      mo = ($urandom % 3 == 0) ? 12 : int'($urandom_range(1, 12));
      dd = ($urandom % 2 == 1) ? dim(mo, y) : int'($urandom_range(1, dim(mo, y)));
      h  = ($urandom % 2 == 1) ? 23 : int'($urandom_range(0, 23));
      mi = ($urandom % 2 == 1) ? 59 : int'($urandom_range(0, 59));
      s  = int'($urandom_range(50, 59));
      t = {b2(h), b2(mi), b2(s)};
      d = {b4(y), b2(mo), b2(dd)};
    end
  endtask

  initial begin
    int cnt;
    logic [55:0] snap;
    logic [23:0] rt;
    logic [31:0] rd;

    rv[0] = '{24'h235959, 32'h2024_0228, 24'h000000, 32'h2024_0229, 1'b1, 1'b0};
    rv[1] = '{24'h235959, 32'h2023_0228, 24'h000000, 32'h2023_0301, 1'b1, 1'b0};
    rv[2] = '{24'h235959, 32'h1900_0228, 24'h000000, 32'h1900_0301, 1'b1, 1'b0};
    rv[3] = '{24'h235959, 32'h2000_0228, 24'h000000, 32'h2000_0229, 1'b1, 1'b0};
    rv[4] = '{24'h235959, 32'h9999_1231, 24'h000000, 32'h0000_0101, 1'b1, 1'b1};
    rv[5] = '{24'h235959, 32'h2024_0229, 24'h000000, 32'h2024_0301, 1'b1, 1'b0};
    rv[6] = '{24'h125959, 32'h2024_0630, 24'h130000, 32'h2024_0630, 1'b0, 1'b0};

    bv[0] = '{24'h120000, 32'h2024_0431};
    bv[1] = '{24'h2A0000, 32'h2024_0615};
    bv[2] = '{24'h120000, 32'h2023_0229};
    bv[3] = '{24'h120060, 32'h2024_0615};
    bv[4] = '{24'h120000, 32'h2024_1315};
    bv[5] = '{24'h120000, 32'h2024_0600};
    bv[6] = '{24'h120000, 32'h20A4_0615};
    bv[7] = '{24'h240000, 32'h2024_0615};

    lif.load_valid = 1'b0;
    lif.load_time  = '0;
    lif.load_date  = '0;

    // reset state and ready rising after release
    repeat (2) @(negedge clk);
    model_reset();
    check_state("reset");
    chk("reset_ready", 64'(lif.load_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(lif.load_ready), 64'd1);

    // 1 Hz prescaler at CLK_HZ=4
    run_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (sec_tick) cnt++;
    end
    chk("ps_ticks", 64'(cnt), 64'd4);
    chk("ps_sec", 64'(sec_bcd), 64'h04);
    run_en = 1'b0;
    repeat (6) tick();
    chk("freeze_sec", 64'(sec_bcd), 64'h04);
    run_en = 1'b1;
    repeat (7) tick();
    run_en = 1'b0;

    // rollover table
    for (int i = 0; i < 7; i++) begin
      run_en = 1'b0; fast = 1'b0;
      lif.load_valid = 1'b1;
      lif.load_time = rv[i].t;
      lif.load_date = rv[i].d;
      tick();
      lif.load_valid = 1'b0;
      tick();
      run_en = 1'b1; fast = 1'b1;
      tick();
      run_en = 1'b0; fast = 1'b0;
      chk("roll_time", 64'({hour_bcd, min_bcd, sec_bcd}), 64'(rv[i].et));
      chk("roll_date", 64'({year_bcd, month_bcd, day_bcd}), 64'(rv[i].ed));
      chk("roll_pulse", 64'({sec_tick, day_tick, year_wrap}),
          64'({1'b1, rv[i].edt, rv[i].eyw}));
    end

    // rejected loads
    lif.load_valid = 1'b1;
    lif.load_time = 24'h102030;
    lif.load_date = 32'h2024_0615;
    tick();
    lif.load_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      snap = {hour_bcd, min_bcd, sec_bcd, year_bcd, month_bcd, day_bcd};
      lif.load_valid = 1'b1;
      lif.load_time = bv[i].t;
      lif.load_date = bv[i].d;
      tick();
      lif.load_valid = 1'b0;
      chk("err_pulse", 64'({lif.load_err, lif.load_ready}), 64'b10);
      chk("err_hold", 64'({hour_bcd, min_bcd, sec_bcd, year_bcd,
          month_bcd, day_bcd}), 64'(snap));
      tick();
      chk("err_clear", 64'({lif.load_err, lif.load_ready}), 64'b01);
    end

    // load coincident with an advance
    run_en = 1'b1; fast = 1'b1;
    lif.load_valid = 1'b1;
    lif.load_time = 24'h123456;
    lif.load_date = 32'h2024_0615;
    tick();
    lif.load_valid = 1'b0;
    chk("coinc_time", 64'({hour_bcd, min_bcd, sec_bcd}), 64'h123456);
    chk("coinc_tick", 64'(sec_tick), 64'd0);
    repeat (3) tick();

    // async reset mid-count
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    chk("async_rst_sec", 64'({year_bcd, sec_bcd}), 64'h2024_00);
    @(negedge clk);
    rst = 1'b0;
    run_en = 1'b0; fast = 1'b0;
    tick();

    // async reset discards a pending load_err
    lif.load_valid = 1'b1;
    lif.load_time = 24'h990000;
    lif.load_date = 32'h2024_0615;
    tick();
    lif.load_valid = 1'b0;
    chk("pend_err", 64'(lif.load_err), 64'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_err", 64'(lif.load_err), 64'd0);
    check_state("rst_mid_load");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      run_en = ($urandom % 4 != 0);
      fast = ($urandom % 3 != 0);
      lif.load_valid = ($urandom % 8 == 0);
      gen_load(rt, rd);
      lif.load_time = rt;
      lif.load_date = rd;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
- Parametrised real-time clock/calendar core: seconds, minutes, hours, day, month and 4-digit year, all held natively as packed BCD.
- Output feeds display decode without conversion.
- Adds a configurable 1 Hz prescaler, run/fast modes, a validated load handshake, full Gregorian leap rules and event pulses.
- Sits between the board clock and the 7-segment display drivers.

Parameters:
- CLK_HZ, 50000000: clk cycles per second. Minimum 1; a value of 1 advances every enabled cycle.
- RESET_YEAR_BCD, 16'h2024: year loaded on reset.
- PS_W, $clog2(CLK_HZ) (minimum 1): prescaler width. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run_en  in  1  1 = time advances; 0 = frozen, prescaler held
- fast  in  1  1 = advance one second per enabled cycle, ignoring the prescaler
- load_valid  in  1  request to load all fields
- load_ready  out  1  core can accept a load
- load_time  in  24  {hour[23:16], min[15:8], sec[7:0]} packed BCD
- load_date  in  32  {year[31:16], month[15:8], day[7:0]} packed BCD
- load_err  out  1  one-cycle pulse: last accepted load was rejected
- sec_bcd, min_bcd, hour_bcd  out  8 each  current time, BCD
- day_bcd, month_bcd  out  8 each  current date, BCD
- year_bcd  out  16  current year, BCD
- sec_tick  out  1  one-cycle pulse when the second advanced
- day_tick  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition
- year_wrap  out  1  one-cycle pulse on the 9999 -> 0000 transition

Behaviour:
- Reset (async assert, sync release):
  - time = 00:00:00; day = 8'h01; month = 8'h01; year = RESET_YEAR_BCD.
  - Prescaler = 0.
  - load_ready = 0, rising to 1 on the first clk edge after release.
  - All pulse outputs = 0.
- Advance condition `adv`:
  - adv = run_en & (fast | prescaler == CLK_HZ-1).
  - Prescaler increments while run_en=1 and wraps to 0 when it reaches CLK_HZ-1.
  - When fast=1, the prescaler is held at 0.
- Latency: every field updates on the same edge at which adv is sampled. sec_tick is registered and asserts in that same cycle as the new values.
- Carry chain, all evaluated in a single cycle:
  - sec 59 -> 00, carries into min.
  - min 59 -> 00, carries into hour.
  - hour 23 -> 00, carries into day; day_tick fires.
  - day equal to days_in_month -> 01, carries into month.
  - month 12 -> 01, carries into year.
  - year 9999 -> 0000; year_wrap fires.
- Days in month:
  - 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - February: 29 if leap, else 28.
  - Leap = divisible by 4 and (not divisible by 100, or divisible by 400).
  - Computed directly on BCD digits:
    - Two-digit group divisible by 4: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
    - Low pair = 00 means the century test applies to the high pair.
- Load handshake:
  - Accept = load_valid & load_ready.
  - The cycle after an accept, load_ready = 0 (one busy cycle); it otherwise stays 1.
- Load validation, on the accept cycle:
  - Every nibble must be <= 9.
  - Ranges: sec <= 59, min <= 59, hour <= 23, month 1..12, day 1..days_in_month(loaded month, loaded year).
  - Valid: all fields are replaced on the next edge and the prescaler is cleared; no pulse.
  - Invalid: no field changes, the prescaler keeps running, and load_err pulses for the cycle after the accept.
- Accept and adv in the same cycle: the load wins, that advance is dropped, and no sec_tick, day_tick or year_wrap is issued.
- run_en=0: fields and prescaler hold; loads are still accepted.
- Reset asserted mid-count or mid-load: immediate return to reset values; any pending load_err is discarded.

Decomposition:
- Package rtc_pkg holds:
  - Field-width localparams.
  - BCD constants for month lengths and the reset date.
  - Function bcd_leap(year16) -> bit.
  - Function bcd_days_in_month(month8, leap) -> 8-bit BCD.
  - Function bcd_valid(nibbles).
- One sub-module, rtc_bcd2_counter: a two-digit BCD counter with parameters MIN and MAX (MAX may also be supplied through a port), plus load, inc and carry-out.
  - Instanced for sec, min, hour, day and month.
  - The year uses two instances chained, each MIN 00 / MAX 99.

Test Plan:
1. Reset release -> fields 00:00:00, 01/01, year 16'h2024; load_ready 0, then 1 on the next edge; all pulses 0.
2. CLK_HZ=4, run_en=1, fast=0 -> sec_tick every 4th cycle; after 16 cycles sec_bcd=8'h04. Drop run_en -> values and prescaler frozen.
3. Leap rollover from 23:59:59 28/02 with fast=1, one advance each:
   - year 2024 -> 29/02.
   - year 2023 -> 01/03.
   - year 1900 -> 01/03.
   - year 2000 -> 29/02.
   - day_tick fires on each.
4. Load 23:59:59 31/12/9999, one fast advance -> 00:00:00 01/01/0000; day_tick=1 and year_wrap=1 in the same cycle.
5. Load 31/04/2024, then hour 8'h2A, then 29/02/2023 -> load_err pulse after each, outputs unchanged, load_ready low one cycle after each accept.
6. load_valid coincident with adv -> loaded values appear exactly, no increment, no sec_tick. rst raised between clk edges mid-count -> outputs reset before the next edge.
